// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit0=a .. bit6=g),
// readback FSM state encoding and a saturating counter helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low 7-segment pattern to a nibble.
// With HEX_MODE=0 the A-F glyphs decode but are reported as illegal.
module seg7_digit_decode
    import seg7_pkg::*;
#(
    parameter int unsigned HEX_MODE = 1
) (
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       legal_o
);

    always_comb begin
        nibble_o = 4'h0;
        legal_o  = 1'b1;
        case (seg_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: legal_o  = 1'b0;
        endcase
        if (HEX_MODE == 0 && nibble_o > 4'h9) legal_o = 1'b0;
    end

endmodule

// File: rtl/seg7_readback.sv
// Reads six active-low 7-segment digit buses back into a 24-bit value,
// accepting a pattern only once it has been stable for STABLE_CYCLES samples.
//
// state  | meaning
// IDLE   | sampling disabled, outputs hold
// SETTLE | counting consecutive samples equal to snap
// LOCKED | stable pattern accepted, waiting for the next change
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned HEX_MODE      = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_en,
    input  logic [6:0]  digit5,
    input  logic [6:0]  digit4,
    input  logic [6:0]  digit3,
    input  logic [6:0]  digit2,
    input  logic [6:0]  digit1,
    input  logic [6:0]  digit0,
    output logic [23:0] value,
    output logic        value_valid,
    output logic        update_pulse,
    output logic        seg_error,
    output logic [5:0]  err_mask,
    output logic [15:0] update_count
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [41:0]        r_dig_q;
    logic [41:0]        snap_q, snap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [23:0]        value_q, value_d;
    logic               valid_q, valid_d;
    logic               pulse_q, pulse_d;
    logic               err_q, err_d;
    logic [5:0]         mask_q, mask_d;
    logic [15:0]        update_count_q, update_count_d;
    logic [23:0]        decoded;
    logic [5:0]         legal;
    logic               lock;

    // snap only changes while not locking, so decoding it equals decoding r_dig at lock time
    for (genvar g = 0; g < 6; g++) begin : g_dec
        seg7_digit_decode #(.HEX_MODE(HEX_MODE)) u_dec (
            .seg_i    (snap_q[7*g +: 7]),
            .nibble_o (decoded[4*g +: 4]),
            .legal_o  (legal[g])
        );
    end

    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        cnt_d          = cnt_q;
        value_d        = value_q;
        valid_d        = valid_q;
        mask_d         = mask_q;
        update_count_d = update_count_q;
        pulse_d        = 1'b0;
        err_d          = 1'b0;
        lock           = 1'b0;

        if (!sample_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    snap_d  = r_dig_q;
                    cnt_d   = '0;
                end
                SETTLE: begin
                    if (r_dig_q != snap_q) begin
                        snap_d = r_dig_q;
                        cnt_d  = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        lock    = 1'b1;
                        state_d = LOCKED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (r_dig_q != snap_q) begin
                        snap_d  = r_dig_q;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (lock) begin
            if (&legal) begin
                value_d = decoded;
                valid_d = 1'b1;
                mask_d  = '0;
                if (!valid_q || decoded != value_q) begin
                    pulse_d        = 1'b1;
                    update_count_d = sat_inc16(update_count_q);
                end
            end else begin
                mask_d = ~legal;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            r_dig_q        <= '0;
            snap_q         <= '0;
            cnt_q          <= '0;
            value_q        <= '0;
            valid_q        <= 1'b0;
            pulse_q        <= 1'b0;
            err_q          <= 1'b0;
            mask_q         <= '0;
            update_count_q <= '0;
        end else begin
            state_q        <= state_d;
            r_dig_q        <= {digit5, digit4, digit3, digit2, digit1, digit0};
            snap_q         <= snap_d;
            cnt_q          <= cnt_d;
            value_q        <= value_d;
            valid_q        <= valid_d;
            pulse_q        <= pulse_d;
            err_q          <= err_d;
            mask_q         <= mask_d;
            update_count_q <= update_count_d;
        end
    end

    assign value        = value_q;
    assign value_valid  = valid_q;
    assign update_pulse = pulse_q;
    assign seg_error    = err_q;
    assign err_mask     = mask_q;
    assign update_count = update_count_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Bench for seg7_readback: directed scenarios plus a randomized run scored
// against a stable-run-length model of the readback rules.
module tb_seg7_readback;

    localparam int SC = 16;
    localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [41:0] pat = '0;
    logic        s1_en = 1'b0;
    logic [41:0] s1_pat = '0;

    logic [23:0] m_value, h_value, s_value;
    logic        m_valid, h_valid, s_valid;
    logic        m_pulse, h_pulse, s_pulse;
    logic        m_err, h_err, s_err;
    logic [5:0]  m_mask, h_mask, s_mask;
    logic [15:0] m_count, h_count, s_count;

    int checks = 0;
    int failures = 0;

    logic [23:0] e_value [2];
    logic        e_valid [2];
    logic        e_pulse [2];
    logic        e_err   [2];
    logic [5:0]  e_mask  [2];
    logic [15:0] e_count [2];

    always #5 clk = ~clk;

    seg7_readback #(.STABLE_CYCLES(SC), .HEX_MODE(1)) dut (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
        .digit5(pat[41:35]), .digit4(pat[34:28]), .digit3(pat[27:21]),
        .digit2(pat[20:14]), .digit1(pat[13:7]), .digit0(pat[6:0]),
        .value(m_value), .value_valid(m_valid), .update_pulse(m_pulse),
        .seg_error(m_err), .err_mask(m_mask), .update_count(m_count));

    seg7_readback #(.STABLE_CYCLES(SC), .HEX_MODE(0)) dut_h0 (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
        .digit5(pat[41:35]), .digit4(pat[34:28]), .digit3(pat[27:21]),
        .digit2(pat[20:14]), .digit1(pat[13:7]), .digit0(pat[6:0]),
        .value(h_value), .value_valid(h_valid), .update_pulse(h_pulse),
        .seg_error(h_err), .err_mask(h_mask), .update_count(h_count));

    seg7_readback #(.STABLE_CYCLES(1), .HEX_MODE(1)) dut_s1 (
        .clk(clk), .reset_n(reset_n), .sample_en(s1_en),
        .digit5(s1_pat[41:35]), .digit4(s1_pat[34:28]), .digit3(s1_pat[27:21]),
        .digit2(s1_pat[20:14]), .digit1(s1_pat[13:7]), .digit0(s1_pat[6:0]),
        .value(s_value), .value_valid(s_valid), .update_pulse(s_pulse),
        .seg_error(s_err), .err_mask(s_mask), .update_count(s_count));

    function automatic logic [41:0] mk(input logic [23:0] v);
        logic [41:0] p;
        p = '0;
        for (int n = 0; n < 6; n++) p[7*n +: 7] = CODES[v[4*n +: 4]];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference lock action: k=0 hex-mode instance, k=1 decimal-only instance
    task automatic model_lock(input logic [41:0] p, input int k);
        logic [23:0] dec;
        logic [5:0]  bad;
        int          idx;
        dec = '0;
        bad = '0;
        for (int n = 0; n < 6; n++) begin
            idx = -1;
            for (int c = 0; c < 16; c++) if (CODES[c] == p[7*n +: 7]) idx = c;
            if (idx < 0 || (k == 1 && idx > 9)) bad[n] = 1'b1;
            else dec[4*n +: 4] = 4'(idx);
        end
        if (bad == 6'd0) begin
            if (!e_valid[k] || dec != e_value[k]) begin
                e_pulse[k] = 1'b1;
                if (e_count[k] != 16'hFFFF) e_count[k] = e_count[k] + 16'd1;
            end
            e_value[k] = dec;
            e_valid[k] = 1'b1;
            e_mask[k]  = '0;
        end else begin
            e_mask[k] = bad;
            e_err[k]  = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sample_en = 1'b0; s1_en = 1'b0;
        pat = mk(24'hABCDEF); s1_pat = mk(24'h000000);
        repeat (3) tick();
        checks++; if (m_value !== 24'h0) begin failures++; $display("FAIL reset value got %h exp 0", m_value); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset valid got %b exp 0", m_valid); end
        checks++; if ({m_pulse, m_err} !== 2'b00) begin failures++; $display("FAIL reset pulses got %b exp 00", {m_pulse, m_err}); end
        checks++; if (m_mask !== 6'h0) begin failures++; $display("FAIL reset err_mask got %b exp 0", m_mask); end
        checks++; if (m_count !== 16'h0) begin failures++; $display("FAIL reset count got %h exp 0", m_count); end
    endtask

    task automatic test_first_lock();
        int pulses = 0;
        int pedge = -1;
        pat = mk(24'hABCDEF); sample_en = 1'b1; reset_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (m_pulse) begin pulses++; pedge = e; end
        end
        checks++; if (pulses !== 1 || pedge !== 18) begin failures++; $display("FAIL first_lock pulses=%0d at edge %0d exp 1 at 18", pulses, pedge); end
        checks++; if (m_value !== 24'hABCDEF) begin failures++; $display("FAIL first_lock value got %h exp abcdef", m_value); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL first_lock valid got %b exp 1", m_valid); end
        checks++; if (m_count !== 16'd1) begin failures++; $display("FAIL first_lock count got %0d exp 1", m_count); end
    endtask

    task automatic test_glitch();
        int events = 0;
        repeat (100) begin tick(); if (m_pulse || m_err) events++; end
        pat[6:0] = 7'h40;
        tick(); if (m_pulse || m_err) events++;
        pat[6:0] = 7'h0E;
        repeat (40) begin tick(); if (m_pulse || m_err) events++; end
        checks++; if (events !== 0) begin failures++; $display("FAIL glitch_same events got %0d exp 0", events); end
        checks++; if (m_count !== 16'd1) begin failures++; $display("FAIL glitch_same count got %0d exp 1", m_count); end
        checks++; if (m_value !== 24'hABCDEF) begin failures++; $display("FAIL glitch_same value got %h exp abcdef", m_value); end
    endtask

    task automatic test_new_value();
        int pulses = 0;
        int pedge = -1;
        pat = mk(24'hABCDF0);
        for (int e = 1; e <= 45; e++) begin
            tick();
            if (m_pulse) begin pulses++; pedge = e; end
            if (e == 8) pat = mk(24'hABCDF1);
            if (e == 9) pat = mk(24'hABCDF0);
        end
        checks++; if (pulses !== 1 || pedge !== 27) begin failures++; $display("FAIL restart pulses=%0d at edge %0d exp 1 at 27", pulses, pedge); end
        checks++; if (m_value !== 24'hABCDF0) begin failures++; $display("FAIL new_value value got %h exp abcdf0", m_value); end
        checks++; if (m_count !== 16'd2) begin failures++; $display("FAIL new_value count got %0d exp 2", m_count); end
    endtask

    task automatic test_hex_mode();
        int hpulse = 0;
        int herr = 0;
        int hedge = -1;
        pat = mk(24'h123456);
        repeat (20) tick();
        checks++; if (h_value !== 24'h123456 || h_valid !== 1'b1) begin failures++; $display("FAIL dec_lock value got %h/%b exp 123456/1", h_value, h_valid); end
        checks++; if (m_count !== 16'd3) begin failures++; $display("FAIL dec_lock main count got %0d exp 3", m_count); end
        pat = mk(24'h12C456);
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (h_err) begin herr++; hedge = e; end
            if (h_pulse) hpulse++;
        end
        checks++; if (herr !== 1 || hedge !== 18) begin failures++; $display("FAIL dec_C seg_error=%0d at edge %0d exp 1 at 18", herr, hedge); end
        checks++; if (h_mask !== 6'b001000) begin failures++; $display("FAIL dec_C err_mask got %b exp 001000", h_mask); end
        checks++; if (h_value !== 24'h123456 || hpulse !== 0) begin failures++; $display("FAIL dec_C value got %h pulses %0d exp 123456 0", h_value, hpulse); end
        checks++; if (m_value !== 24'h12C456 || m_count !== 16'd4) begin failures++; $display("FAIL hex_C value/count got %h/%0d exp 12c456/4", m_value, m_count); end
    endtask

    task automatic test_blank();
        int errs = 0;
        int eedge = -1;
        pat = mk(24'h12C456);
        pat[20:14] = 7'h7F;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (m_err) begin errs++; eedge = e; end
        end
        checks++; if (errs !== 1 || eedge !== 18) begin failures++; $display("FAIL blank seg_error=%0d at edge %0d exp 1 at 18", errs, eedge); end
        checks++; if (m_mask !== 6'b000100) begin failures++; $display("FAIL blank err_mask got %b exp 000100", m_mask); end
        checks++; if (m_valid !== 1'b1 || m_value !== 24'h12C456 || m_count !== 16'd4) begin failures++; $display("FAIL blank hold got %b/%h/%0d exp 1/12c456/4", m_valid, m_value, m_count); end
    endtask

    task automatic test_disable();
        int events = 0;
        int pulses = 0;
        int pedge = -1;
        sample_en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c % 5 == 0) pat = mk(24'($urandom));
            if (c == 35) pat = mk(24'h111111);
            tick();
            if (m_pulse || m_err) events++;
        end
        checks++; if (events !== 0) begin failures++; $display("FAIL disabled events got %0d exp 0", events); end
        checks++; if (m_value !== 24'h12C456 || m_mask !== 6'b000100 || m_count !== 16'd4) begin failures++; $display("FAIL disabled hold got %h/%b/%0d exp 12c456/000100/4", m_value, m_mask, m_count); end
        pat = mk(24'h654321); sample_en = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (m_pulse) begin pulses++; pedge = e; end
        end
        checks++; if (pulses !== 1 || pedge !== 18) begin failures++; $display("FAIL reenable pulses=%0d at edge %0d exp 1 at 18", pulses, pedge); end
        checks++; if (m_value !== 24'h654321 || m_mask !== 6'h0 || m_count !== 16'd5) begin failures++; $display("FAIL reenable got %h/%b/%0d exp 654321/0/5", m_value, m_mask, m_count); end
    endtask

    task automatic test_saturation();
        logic [2:0]  seen;
        logic [15:0] exp_cnt;
        s1_pat = mk(24'd1); s1_en = 1'b1;
        for (int i = 0; i < 101; i++) begin
            if (i > 0) s1_pat = mk(24'(i + 1));
            seen = '0;
            for (int e = 0; e < 3; e++) begin tick(); seen[e] = s_pulse; end
            checks++; if (seen !== 3'b100) begin failures++; $display("FAIL s1_latency update %0d pulses %b exp 100", i, seen); end
        end
        checks++; if (s_count !== 16'd101 || s_value !== 24'd101) begin failures++; $display("FAIL s1_count got %0d/%h exp 101/000065", s_count, s_value); end
        checks++; if (s_err !== 1'b0 || s_mask !== 6'h0 || s_valid !== 1'b1) begin failures++; $display("FAIL s1_flags got %b/%b/%b exp 0/0/1", s_err, s_mask, s_valid); end
        force dut_s1.update_count_q = 16'hFFFD;
        tick();
        release dut_s1.update_count_q;
        tick();
        exp_cnt = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            s1_pat = mk(24'(200 + i));
            seen = '0;
            for (int e = 0; e < 3; e++) begin tick(); seen[e] = s_pulse; end
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            checks++; if (seen !== 3'b100 || s_count !== exp_cnt) begin failures++; $display("FAIL saturate step %0d pulses %b count %h exp 100 %h", i, seen, s_count, exp_cnt); end
        end
    endtask

    task automatic test_async_reset();
        pat = mk(24'h777777);
        repeat (8) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({m_value, m_valid, m_pulse, m_err, m_mask, m_count} !== '0) begin failures++; $display("FAIL async_reset main got %h/%b/%b/%b/%b/%h exp all 0", m_value, m_valid, m_pulse, m_err, m_mask, m_count); end
        checks++; if (s_count !== 16'h0 || s_valid !== 1'b0) begin failures++; $display("FAIL async_reset s1 got %h/%b exp 0/0", s_count, s_valid); end
        tick();
    endtask

    task automatic test_random();
        logic [41:0] pool [5];
        int          holds [8] = '{1, 2, 3, 16, 17, 18, 24, 40};
        logic [41:0] m_prev;
        logic [41:0] lp;
        logic [41:0] tmp;
        logic [23:0] dv;
        logic [48:0] obs, expv;
        logic        lock;
        int          m_run;
        int          cyc;
        int          len;
        for (int i = 0; i < 3; i++) pool[i] = mk(24'($urandom));
        dv = '0;
        for (int n = 0; n < 6; n++) dv[4*n +: 4] = 4'($urandom_range(0, 9));
        pool[3] = mk(dv);
        tmp = mk(24'($urandom));
        tmp[7*$urandom_range(0, 5) +: 7] = 7'($urandom);
        pool[4] = tmp;
        for (int i = 0; i < 5; i++) if (pool[i] == '0) pool[i][0] = 1'b1;

        reset_n = 1'b0; sample_en = 1'b1; pat = pool[0];
        tick(); tick();
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e_value[k] = '0; e_valid[k] = 1'b0; e_pulse[k] = 1'b0;
            e_err[k] = 1'b0; e_mask[k] = '0; e_count[k] = '0;
        end
        m_prev = '0; m_run = 0; cyc = 0;
        while (cyc < 1500) begin
            pat = pool[$urandom_range(0, 4)];
            len = holds[$urandom_range(0, 7)];
            for (int c = 0; c < len; c++) begin
                tick();
                cyc++;
                lock = (m_run == SC + 1);
                lp = m_prev;
                if (pat == m_prev) m_run++;
                else begin m_prev = pat; m_run = 1; end
                for (int k = 0; k < 2; k++) begin
                    e_pulse[k] = 1'b0;
                    e_err[k] = 1'b0;
                    if (lock) model_lock(lp, k);
                end
                for (int k = 0; k < 2; k++) begin
                    obs = (k == 0) ? {m_pulse, m_err, m_valid, m_mask, m_value, m_count}
                                   : {h_pulse, h_err, h_valid, h_mask, h_value, h_count};
                    expv = {e_pulse[k], e_err[k], e_valid[k], e_mask[k], e_value[k], e_count[k]};
                    checks++;
                    if (obs !== expv) begin
                        failures++;
                        $display("FAIL random inst %0d cycle %0d {pulse,err,valid,mask,value,count} got %h exp %h", k, cyc, obs, expv);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_lock();
        test_glitch();
        test_new_value();
        test_hex_mode();
        test_blank();
        test_disable();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Decodes the six active-low 7-segment digit buses produced by drive_6dig_7segs back into a 24-bit value.
- Accepts a value only after it has been stable for STABLE_CYCLES clocks.
- Reports updates, illegal segment patterns and an update count.
- Sits beside the display driver on the DE10-Lite for on-hardware self-checking: the loopback/reader end of the 7-segment interface.

Parameters:
- STABLE_CYCLES, 16: consecutive matching samples required before lock. Legal range 1..65535.
- HEX_MODE, 1: 1 = patterns A–F are legal; 0 = only 0–9 are legal, A–F are flagged illegal.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- sample_en  in  1  enables sampling; 0 = hold outputs.
- digit5..digit0  in  7 each  active-low segments, bit0=a … bit6=g. digit5 is the left-most digit (value[23:20]).
- value  out  24  last locked decoded value.
- value_valid  out  1  high once any legal value has locked.
- update_pulse  out  1  one-cycle pulse when a locked value differs from the previous one (or is the first lock).
- seg_error  out  1  one-cycle pulse when a stable pattern contains an illegal digit.
- err_mask  out  6  illegal digits of the last erroring lock; bit n = digitn.
- update_count  out  16  number of update_pulses; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync deassert by design use): state=IDLE, all outputs 0, internal registers 0.
- Input stage: all 42 digit bits registered once (r_dig). Inputs are same-clock-domain; no synchroniser.
- States:
  - IDLE: when sample_en=1 → SETTLE with snap<=r_dig, cnt<=0.
  - SETTLE:
    - r_dig!=snap → snap<=r_dig, cnt<=0.
    - Match and cnt<STABLE_CYCLES-1 → cnt++.
    - Match and cnt==STABLE_CYCLES-1 → LOCK action → LOCKED.
  - LOCKED: r_dig!=snap → snap<=r_dig, cnt<=0, SETTLE. Otherwise hold; no repeat pulses.
  - Any state, sample_en=0 → IDLE, cnt<=0. value, value_valid, err_mask and update_count hold. No pulses while in IDLE.
- LOCK action:
  - Decode all six digits.
  - All legal:
    - value<=decoded, value_valid<=1, err_mask<=0.
    - If !value_valid or decoded!=value: update_pulse<=1, update_count<=sat_inc.
  - Any illegal: err_mask<=illegal bits, seg_error<=1. value and value_valid unchanged.
- Latency: a new pattern held from before rising edge E1 produces update_pulse/seg_error registered at edge E(STABLE_CYCLES+2). Default STABLE_CYCLES=16 → 18 edges. STABLE_CYCLES=1 → 3 edges.
- Legal codes (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. Blank (7F) and all others are illegal.
- A glitch of a single differing sample restarts the full settle count.
- Reset asserted mid-settle or mid-lock returns everything to reset values immediately.
- cnt width is $clog2(STABLE_CYCLES)+1.

Decomposition:
- Package seg7_pkg holds:
  - The 16 localparam segment codes (shared with drive_6dig_7segs).
  - The state encoding (IDLE=0, SETTLE=1, LOCKED=2).
  - A BLANK=7'h7F constant.
- Sub-module seg7_digit_decode: 7-bit pattern + HEX_MODE → 4-bit nibble + legal flag, purely combinational. Instantiated 6×.

Test Plan:
- Reset, sample_en=1, digits=ab_cdef codes held 20 clocks → update_pulse exactly once at edge 18; value=24'hABCDEF, value_valid=1, update_count=1.
- Same pattern held 100 further clocks, then a one-cycle glitch on digit0 → no extra pulse. Settle restarts; re-lock to same value gives no update_pulse, count stays 1.
- Digits → ab_cdf0, and separately HEX_MODE=0 with digit3=C (46) → first: pulse, value=ABCDF0, count=2. Second: seg_error pulse, err_mask=6'b001000, value unchanged.
- digit2=7F (blank) held → seg_error, err_mask=6'b000100, value_valid unchanged. Then sample_en=0 while a new pattern changes → no pulses, outputs hold. Re-enable → lock after 18 edges.
- Force update_count to 16'hFFFF via 65535 alternating values with STABLE_CYCLES=1 → the next update keeps update_count=FFFF. reset_n low mid-SETTLE → all outputs 0 asynchronously.
